// File: rtl/seq_div32x16_pkg.sv
// div_pkg: shared widths and FSM state type for the seq_div32x16 divider.
//   DIV_N   quotient / remainder / divisor width
//   DIV_RW  width of the restoring step's shifted partial remainder T
//   DIV_AW  dividend width
//   DIV_CW  iteration counter width
package div_pkg;

  localparam int unsigned DIV_N  = 16;
  localparam int unsigned DIV_RW = DIV_N + 1;
  localparam int unsigned DIV_AW = 2 * DIV_N;
  localparam int unsigned DIV_CW = $clog2(DIV_N);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/seq_div32x16_if.sv
// seq_div32x16_if: start/busy/done handshake and operand/result bus.
//   start  request, sampled only while busy=0
//   a      dividend (DIV_AW bits), sampled on accepted start
//   b      divisor (DIV_N bits), sampled on accepted start
//   busy   operation in progress
//   done   one-cycle result-valid pulse
//   q, r   quotient / remainder, held until the next done
//   ovf    overflow / divide-by-zero flag, qualified by done
// master = controller side, slave = divider side.
interface seq_div32x16_if;
  import div_pkg::*;

  logic              start;
  logic [DIV_AW-1:0] a;
  logic [DIV_N-1:0]  b;
  logic              busy;
  logic              done;
  logic [DIV_N-1:0]  q;
  logic [DIV_N-1:0]  r;
  logic              ovf;

  modport master (
    output start, a, b,
    input  busy, done, q, r, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, ovf
  );

endinterface

// File: rtl/seq_div32x16_div_step.sv
// div_step: one combinational restoring-division step.
//   r_in   current partial remainder (low DIV_N bits)
//   bit_in next dividend bit shifted in
//   d      divisor
//   r_out  new partial remainder (low DIV_N bits)
//   qbit   resolved quotient bit
module div_step
  import div_pkg::*;
(
  input  logic [DIV_N-1:0] r_in,
  input  logic             bit_in,
  input  logic [DIV_N-1:0] d,
  output logic [DIV_N-1:0] r_out,
  output logic             qbit
);

  logic [DIV_RW-1:0] t;
  logic [DIV_RW-1:0] dx;

  always_comb begin
    t     = {r_in, bit_in};
    dx    = {1'b0, d};
    qbit  = (t >= dx);
    // Only the low DIV_N bits of R ever feed the next step or the result,
    // so the remainder's top bit is not carried.
    r_out = qbit ? DIV_N'(t - dx) : t[DIV_N-1:0];
  end

endmodule

// File: rtl/seq_div32x16.sv
// seq_div32x16: sequential restoring divider, 32-bit unsigned dividend by
// 16-bit unsigned divisor, one quotient bit per clock (latency DIV_N).
//   clk  rising-edge clock
//   rst  synchronous active-high reset, aborts any operation in flight
//   dif  seq_div32x16_if.slave: start/a/b in, busy/done/q/r/ovf out
// Optional macro DIV_OVF_DETECT_EN: at start, b==0 or a_hi>=b finishes in
// one cycle with ovf=1, q=all-ones, r=a_lo. Without it ovf is always 0 and
// every operation runs the full DIV_N iterations.
module seq_div32x16
  import div_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  seq_div32x16_if.slave  dif
);

  state_t            state, state_nx;
  logic [DIV_N-1:0]  rreg;   // partial remainder R (top bit never observable)
  logic [DIV_N-1:0]  qreg;   // dividend low half shifting out / quotient in
  logic [DIV_N-1:0]  dreg;
  logic [DIV_CW-1:0] cnt;
  logic [DIV_N-1:0]  q_q, r_q;
  logic              ovf_q, done_q;

  logic [DIV_N-1:0]  step_r;
  logic              step_qbit;
  logic              accept, early, last;

  div_step u_step (
    .r_in   (rreg),
    .bit_in (qreg[DIV_N-1]),
    .d      (dreg),
    .r_out  (step_r),
    .qbit   (step_qbit)
  );

`ifdef DIV_OVF_DETECT_EN
  assign early = (dif.b == '0) || (dif.a[DIV_AW-1:DIV_N] >= dif.b);
`else
  assign early = 1'b0;
`endif

  assign accept = (state == IDLE) && dif.start;
  assign last   = (state == RUN) && (cnt == DIV_CW'(DIV_N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && !early) state_nx = RUN;
      RUN:  if (last)             state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    dif.busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rreg   <= '0;
      qreg   <= '0;
      dreg   <= '0;
      cnt    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (early) begin
          q_q    <= '1;
          r_q    <= dif.a[DIV_N-1:0];
          ovf_q  <= 1'b1;
          done_q <= 1'b1;
        end else begin
          rreg <= dif.a[DIV_AW-1:DIV_N];
          qreg <= dif.a[DIV_N-1:0];
          dreg <= dif.b;
          cnt  <= '0;
        end
      end else if (state == RUN) begin
        rreg <= step_r;
        qreg <= {qreg[DIV_N-2:0], step_qbit};
        cnt  <= cnt + 1'b1;
        if (last) begin
          q_q    <= {qreg[DIV_N-2:0], step_qbit};
          r_q    <= step_r;
          ovf_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign dif.done = done_q;
  assign dif.q    = q_q;
  assign dif.r    = r_q;
  assign dif.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_div32x16.sv
// tb_seq_div32x16: directed self-checking bench for seq_div32x16 with a
// scoreboard queue of expected results (pushed at issue, popped at done).
module tb_seq_div32x16;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_div32x16_if dif ();

  seq_div32x16 dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    int          dly;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t_acc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero gives the documented
  // all-ones quotient with the dividend's low half as remainder.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a[15:0];
`ifdef DIV_OVF_DETECT_EN
      e.ovf = 1'b1;
      e.dly = 0;
`else
      e.ovf = 1'b0;
      e.dly = 16;
`endif
    end else begin
      e.q   = 16'(a / {16'd0, b});
      e.r   = 16'(a % {16'd0, b});
      e.ovf = 1'b0;
      e.dly = 16;
    end
    return e;
  endfunction

  // Called at #1 after an edge; returns #1 after the edge that samples start.
  task automatic issue(input logic [31:0] a, input logic [15:0] b, input bit hold, input bit expect_result);
    dif.start = 1'b1;
    dif.a     = a;
    dif.b     = b;
    if (expect_result) sb.push_back(model(a, b));
    @(posedge clk); #1;
    t_acc = cyc;
    if (!hold) dif.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (dif.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (dif.done !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(dif.done), 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected_done"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"},   32'(dif.q),         32'(e.q));
      chk({tag, "_r"},   32'(dif.r),         32'(e.r));
      chk({tag, "_ovf"}, 32'(dif.ovf),       32'(e.ovf));
      chk({tag, "_dly"}, 32'(cyc - t_acc),   32'(e.dly));
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (dif.done === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    dif.start = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
    rst       = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_q",    32'(dif.q),    32'd0);
    chk("rst_r",    32'(dif.r),    32'd0);
    chk("rst_ovf",  32'(dif.ovf),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(32'd100, 16'd7, 1'b0, 1'b1);
    chk("t1_busy", 32'(dif.busy), 32'd1);
    wait_done("t1");
    chk("t1_busy_at_done", 32'(dif.busy), 32'd0);

    issue(32'hFFFE0001, 16'hFFFF, 1'b0, 1'b1);
    wait_done("t2");

    issue(32'h12345678, 16'd0, 1'b0, 1'b1);
`ifdef DIV_OVF_DETECT_EN
    chk("t3_busy", 32'(dif.busy), 32'd0);
`else
    chk("t3_busy", 32'(dif.busy), 32'd1);
`endif
    wait_done("t3");

    // Back-to-back: start stays high through the first done; operands
    // change while busy and are picked up only by the second accept.
    @(posedge clk); #1;
    issue(32'd1000, 16'd10, 1'b1, 1'b1);
    dif.a = 32'h00010000;
    dif.b = 16'd3;
    sb.push_back(model(32'h00010000, 16'd3));
    wait_done("b2b_1");
    @(posedge clk); #1;
    t_acc = cyc;
    chk("b2b_accept_busy", 32'(dif.busy), 32'd1);
    dif.start = 1'b0;
    wait_done("b2b_2");

    // Start pulsed mid-operation is ignored.
    @(posedge clk); #1;
    issue(32'd100, 16'd7, 1'b0, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    dif.start = 1'b1;
    dif.a     = 32'd5000;
    dif.b     = 16'd9;
    @(posedge clk); #1;
    dif.start = 1'b0;
    wait_done("ign");
    watch_no_done("ign_extra_done", 20);

    // Reset mid-run with a coincident start: abort, no done, start dropped.
    issue(32'd1000, 16'd10, 1'b0, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    rst       = 1'b1;
    dif.start = 1'b1;
    dif.a     = 32'd100;
    dif.b     = 16'd7;
    @(posedge clk); #1;
    rst       = 1'b0;
    dif.start = 1'b0;
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_done", 32'(dif.done), 32'd0);
    chk("abort_q",    32'(dif.q),    32'd0);
    chk("abort_r",    32'(dif.r),    32'd0);
    chk("abort_ovf",  32'(dif.ovf),  32'd0);
    @(posedge clk); #1;
    chk("abort_start_dropped", 32'(dif.busy), 32'd0);
    watch_no_done("abort_no_done", 20);

    issue(32'd123456789, 16'd50000, 1'b0, 1'b1);
    wait_done("fresh");

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
